// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default datapath sizing, the adder's stage
// register layout and the add/subtract mode encoding used by the multiplier.
package arith_pkg;

  localparam int ARITH_WIDTH   = 16;
  localparam int ARITH_STAGE_W = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } arith_mode_e;

  // Default-sized stage register; parameterised adders build the same layout locally.
  typedef struct packed {
    logic                   valid;
    logic [ARITH_WIDTH-1:0] sum_lo;
    logic [ARITH_WIDTH-1:0] a_hi;
    logic [ARITH_WIDTH-1:0] b_hi;
    logic                   carry;
  } stage_reg_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bus of the pipelined adder: valid/ready on both sides.
interface pipelined_adder_if #(
  parameter int WIDTH = arith_pkg::ARITH_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational ripple of full-adder cells covering one pipeline slice.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one STAGE_W-bit slice resolved per stage behind an
// operand capture register, with a single global stall driven by the output side.
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH   = ARITH_WIDTH,
  parameter int STAGE_W = ARITH_STAGE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / STAGE_W;

  generate
    if ((WIDTH % STAGE_W) != 0 || STAGES < 1) begin : g_bad_width
      $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of STAGE_W");
    end
  endgenerate

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             carry;
  } stage_t;

  // Entry 0 holds the captured (conditionally inverted) operands; entry k holds
  // the word after slice k-1 has been resolved, so the last entry is the result.
  stage_t pipe_reg  [STAGES+1];
  stage_t pipe_next [STAGES+1];
  logic   ovf_reg;
  logic   ovf_next;
  logic   stall;

  logic [STAGE_W-1:0] slice_sum  [1:STAGES];
  logic               slice_cout [1:STAGES];

  assign stall        = pipe_reg[STAGES].valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      adder_slice #(.W(STAGE_W)) u_slice (
        .a    (pipe_reg[gi-1].a_hi[(gi-1)*STAGE_W +: STAGE_W]),
        .b    (pipe_reg[gi-1].b_hi[(gi-1)*STAGE_W +: STAGE_W]),
        .cin  (pipe_reg[gi-1].carry),
        .sum  (slice_sum[gi]),
        .cout (slice_cout[gi])
      );
    end
  endgenerate

  always_comb begin
    pipe_next[0].valid  = bus.in_valid;
    pipe_next[0].sum_lo = '0;
    pipe_next[0].a_hi   = bus.a;
    pipe_next[0].b_hi   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
    pipe_next[0].carry  = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
    for (int k = 1; k <= STAGES; k++) begin
      pipe_next[k] = pipe_reg[k-1];
      pipe_next[k].sum_lo[(k-1)*STAGE_W +: STAGE_W] = slice_sum[k];
      pipe_next[k].carry = slice_cout[k];
    end
    // Carry into the MSB is recovered from the MSB's own sum bit and operands.
    ovf_next = (pipe_reg[STAGES-1].a_hi[WIDTH-1] ^ pipe_reg[STAGES-1].b_hi[WIDTH-1]
                ^ slice_sum[STAGES][STAGE_W-1]) ^ slice_cout[STAGES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        pipe_reg[k] <= '0;
      end
      ovf_reg <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k <= STAGES; k++) begin
        pipe_reg[k] <= pipe_next[k];
      end
      ovf_reg <= ovf_next;
    end
  end

  assign bus.out_valid = pipe_reg[STAGES].valid;
  assign bus.sum       = pipe_reg[STAGES].sum_lo;
  assign bus.cout      = pipe_reg[STAGES].carry;
  assign bus.ovf       = ovf_reg;

  // Operand copies are fully consumed by the time a word reaches the output.
  logic unused_operands;
  assign unused_operands = ^{pipe_reg[STAGES].a_hi, pipe_reg[STAGES].b_hi};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed words, backpressure,
// bubbles and mid-stream reset, checked against an integer arithmetic model.
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   lat_check = 1'b1;
  exp_t exp_q[$];

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    exp_t e;
    int   sa = $signed(a);
    int   sb = $signed(b);
    int   r;
    int   ua = int'(a);
    int   ub = int'(b);
    if (!s) begin
      r      = sa + sb + int'(c);
      e.sum  = W'(ua + ub + int'(c));
      e.cout = (ua + ub + int'(c)) >= (1 << W);
    end else begin
      r      = sa - sb;
      e.sum  = W'(ua - ub);
      e.cout = (ua >= ub);
    end
    e.ovf = (r > 32767) || (r < -32768);
    e.acc = 0;
    return e;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [W-1:0] a_v, logic [W-1:0] b_v, logic c_v, logic s_v);
    bit   done = 1'b0;
    int   waitc = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a = a_v;
    bus.b = b_v;
    bus.cin = c_v;
    bus.sub = s_v;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(a_v, b_v, c_v, s_v);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        $display("in  a=%04h b=%04h cin=%0d sub=%0d", a_v, b_v, c_v, s_v);
        done = 1'b1;
      end else if (++waitc > 100) begin
        chk("accept_timeout", 32'(waitc), 0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every drained result, checks hold during stalls.
  initial begin
    bit           stall_prev = 1'b0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.out_valid) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        chk("hold_sum", 32'(bus.sum), 32'(prev_sum));
        chk("hold_flags", {30'd0, bus.cout, bus.ovf}, {30'd0, prev_cout, prev_ovf});
      end
      if (!bus.out_ready) begin
        chk("stall_in_ready", 32'(bus.in_ready), 0);
        prev_sum = bus.sum;
        prev_cout = bus.cout;
        prev_ovf = bus.ovf;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: got sum=%04h with no word outstanding", bus.sum);
        end else begin
          e = exp_q.pop_front();
          $display("out sum=%04h cout=%0d ovf=%0d", bus.sum, bus.cout, bus.ovf);
          chk("sum", 32'(bus.sum), 32'(e.sum));
          chk("cout", 32'(bus.cout), 32'(e.cout));
          chk("ovf", 32'(bus.ovf), 32'(e.ovf));
          if (lat_check) chk("latency", 32'(cyc - e.acc), LAT);
        end
      end
    end
  end

  initial begin
    bit drv_done;
    int t;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_flags", {30'd0, bus.cout, bus.ovf}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Directed arithmetic corners
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    idle(6);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    idle(8);

    // Bubbles: alternate valid and idle cycles
    for (int i = 0; i < 6; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      idle(1);
    end
    idle(8);

    // Backpressure: 8 words, consumer stalled for 3 cycles at first result
    lat_check = 1'b0;
    fork
      for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
      begin
        bus.out_ready = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) chk("bp_first_result", 32'(t), 0);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle(10);

    // Random stream with random consumer readiness
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
          idle($urandom_range(2));
        end
        drv_done = 1'b1;
      end
      begin
        t = 0;
        while (!(drv_done && exp_q.size() == 0) && t < 2000) begin
          bus.out_ready = ($urandom_range(3) != 0);
          @(posedge clk);
          #1;
          t++;
        end
        bus.out_ready = 1'b1;
        if (t >= 2000) chk("random_drain", 32'(exp_q.size()), 0);
      end
    join
    idle(4);

    // Reset with three words in flight, oldest already on the outputs
    lat_check = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h0001, 1'b0, 1'b1);
    idle(2);
    chk("pre_reset_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_sum", 32'(bus.sum), 0);
    chk("async_flags", {30'd0, bus.cout, bus.ovf}, 0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(8);
    send(16'hABCD, 16'h1234, 1'b1, 1'b0);
    idle(8);

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined N-bit adder/subtractor that grows the single-bit full adder into a multi-bit datapath.
- Operands are split into STAGE_W-bit slices, and each pipeline stage resolves one slice's carry.
- Provides valid/ready handshakes on both sides, so it drops into the multiplier's partial-product summation tree or any streaming arithmetic path.
- Throughput is one operation per cycle; latency is WIDTH/STAGE_W cycles.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGE_W, 4, bits resolved per pipeline stage. WIDTH % STAGE_W must be 0, otherwise elaboration fails.
- STAGES, WIDTH/STAGE_W (derived localparam), pipeline depth and latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand word present
- in_ready  out  1  block can accept an operand word this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (computed as A+~B+1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- sum  out  WIDTH  result modulo 2^WIDTH
- cout  out  1  carry-out of MSB; in subtract mode 1 means no borrow
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit, data register and carry register. All outputs read 0, except in_ready, which reads 1 once reset is deasserted.
- Accept: a transfer happens when in_valid && in_ready at a rising edge. At accept, b is conditionally inverted and the effective carry is sub ? 1 : cin.
- Stage k (k = 0..STAGES-1): adds slice [k*STAGE_W +: STAGE_W] of A and B' plus the carry registered from stage k-1. It registers the slice result and carry-out.
- Operand skew: unresolved upper slices travel with the word through the pipeline. Resolved lower slices are carried forward, so sum is assembled in order at the last stage.
- Latency: a word accepted at edge n is on the outputs with out_valid=1 after edge n+STAGES.
- ovf: the last stage also registers the carry into the MSB.
- Stall model (global):
  - stall = out_valid && !out_ready.
  - During a stall, every stage register holds and in_ready = 0.
  - in_ready = !stall, combinational from out_valid and out_ready.
- Bubbles: valid bits propagate independently. Empty stages advance when not stalled, so a word never waits behind a bubble.
- Output stability: while out_valid && !out_ready, sum, cout and ovf are held stable.
- Simultaneous events:
  - out_ready rising in the same cycle as in_valid: the accept and the drain both occur on that edge.
  - Full pipeline with out_ready high: accepts one and emits one per cycle, with no loss.
- Reset mid-operation: all in-flight words are discarded. out_valid drops immediately, without waiting for a clock edge. No stale word appears after rst_n is released.
- Wrap-around: the sum is modulo 2^WIDTH. cout and ovf report the wrap.

Decomposition:
- Shared package arith_pkg:
  - default WIDTH / STAGE_W constants;
  - stage register struct (valid, sum_lo, a_hi, b_hi, carry);
  - an ADD/SUB mode encoding for use by the multiplier's control.
- Sub-module adder_slice (STAGE_W-bit combinational ripple of full-adder cells, cin/cout): instantiated once per stage in a generate loop.
- All pipeline registers and the stall logic live in pipelined_adder.

Test Plan (WIDTH=16, STAGE_W=4, latency 4):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 → 4 cycles after accept: sum=0x5555, cout=0, ovf=0, out_valid pulses for 1 cycle.
- Full carry ripple: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back words (a=i, b=i, i=1..8) with out_ready held low for 3 cycles once the first result appears.
  - in_ready is 0 during those cycles and sum is held.
  - Outputs are 2,4,…,16 in order, with no loss or duplication.
- Bubbles: in_valid alternates 1/0 → results are 4 cycles apart from their own accepts, and out_valid alternates to match.
- Reset mid-stream: pull rst_n low with 3 words in flight → out_valid=0 immediately, all outputs 0. After release, no result appears until a new accept plus 4 cycles.
